// File: rtl/clk_gen.sv
// clk_gen: programmable clock/pulse generator.
//
// Divides clk into a square wave clk_out whose half-period is set by
// puls_period. A value of 0 is treated as 1. While disabled, clk_out holds
// start_value. A new puls_period is latched only at a toggle boundary, so a
// phase that is already running is never shortened or stretched.
//
// Optional feature (macro CLK_GEN_EDGE_STROBE_EN): adds rise_stb/fall_stb.
// Each is a registered one-cycle pulse in the same cycle that clk_out changes
// 0->1 or 1->0, including the return to idle on disable.
//
// Parameters:
//   PERIOD_W     width of puls_period and of the half-period counter
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous reset, active-high
//   enable       1 = generate waveform, 0 = hold idle level
//   start_value  idle level; also the first level after enable
//   puls_period  half-period in clk cycles (0 treated as 1)
//   clk_out      generated waveform, registered
//   rise_stb     (CLK_GEN_EDGE_STROBE_EN) clk_out 0->1 this cycle
//   fall_stb     (CLK_GEN_EDGE_STROBE_EN) clk_out 1->0 this cycle
module clk_gen #(
  parameter int unsigned PERIOD_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                start_value,
  input  logic [PERIOD_W-1:0] puls_period,
  output logic                clk_out
`ifdef CLK_GEN_EDGE_STROBE_EN
  ,
  output logic                rise_stb,
  output logic                fall_stb
`endif
);

  logic [PERIOD_W-1:0] cnt;
  logic [PERIOD_W-1:0] per_q;
  logic                en_q;

  logic [PERIOD_W-1:0] per_eff;
  logic [PERIOD_W-1:0] cnt_nxt;
  logic [PERIOD_W-1:0] per_nxt;
  logic                en_nxt;
  logic                out_nxt;

  assign per_eff = (puls_period == '0) ? PERIOD_W'(1) : puls_period;

  always_comb begin
    cnt_nxt = cnt;
    per_nxt = per_q;
    en_nxt  = enable;
    out_nxt = clk_out;
    if (!enable) begin
      cnt_nxt = '0;
      per_nxt = per_eff;
      out_nxt = start_value;
    end else if (!en_q) begin
      // The enable-rise cycle already counts as the first of the half-period.
      cnt_nxt = PERIOD_W'(1);
      per_nxt = per_eff;
    end else if (cnt == per_q) begin
      cnt_nxt = PERIOD_W'(1);
      per_nxt = per_eff;
      out_nxt = ~clk_out;
    end else begin
      cnt_nxt = cnt + PERIOD_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      per_q   <= PERIOD_W'(1);
      en_q    <= 1'b0;
      clk_out <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      per_q   <= per_nxt;
      en_q    <= en_nxt;
      clk_out <= out_nxt;
    end
  end

`ifdef CLK_GEN_EDGE_STROBE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise_stb <= 1'b0;
      fall_stb <= 1'b0;
    end else begin
      rise_stb <= ~clk_out & out_nxt;
      fall_stb <= clk_out & ~out_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_clk_gen.sv
// tb_clk_gen: self-checking bench for clk_gen.
//
// A countdown reference model tracks the expected clk_out level (and, with
// CLK_GEN_EDGE_STROBE_EN, the edge strobes). Directed scenarios measure
// phase lengths directly; a randomized run compares against the model.
module tb_clk_gen;

  localparam int unsigned PERIOD_W = 4;

  logic                clk;
  logic                rst;
  logic                enable;
  logic                start_value;
  logic [PERIOD_W-1:0] puls_period;
  logic                clk_out;
`ifdef CLK_GEN_EDGE_STROBE_EN
  logic                rise_stb;
  logic                fall_stb;
`endif

  int checks;
  int errors;

  // Reference model state
  logic m_level;
  bit   m_active;
  int   m_rem;
  logic m_rise;
  logic m_fall;

  clk_gen #(.PERIOD_W(PERIOD_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .start_value (start_value),
    .puls_period (puls_period),
    .clk_out     (clk_out)
`ifdef CLK_GEN_EDGE_STROBE_EN
    ,
    .rise_stb    (rise_stb),
    .fall_stb    (fall_stb)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_level  = 1'b0;
    m_active = 0;
    m_rem    = 0;
    m_rise   = 1'b0;
    m_fall   = 1'b0;
  endtask

  // One enabled clk edge: remaining cycles of the phase count down; at zero
  // the level flips and a fresh half-period begins with the current setting.
  task automatic model_step();
    logic prev;
    int   n;
    prev = m_level;
    n    = (puls_period == 0) ? 1 : int'(puls_period);
    if (!enable) begin
      m_level  = start_value;
      m_active = 0;
    end else if (!m_active) begin
      m_active = 1;
      m_rem    = n;
    end else begin
      m_rem = m_rem - 1;
      if (m_rem == 0) begin
        m_level = ~m_level;
        m_rem   = n;
      end
    end
    m_rise = !prev && m_level;
    m_fall = prev && !m_level;
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    #1;
  endtask

  // Number of ticks until clk_out leaves lvl; -1 if it never does.
  task automatic phase_len(input logic lvl, output int len);
    len = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (clk_out !== lvl) begin
        len = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    // Disturb a running generator, then reset mid-operation.
    enable = 1'b1; start_value = 1'b0; puls_period = 4'd3;
    repeat (5) tick();
    start_value = 1'b1;
    enable = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (clk_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_async clk_out=%b expected=0", clk_out);
    end
`ifdef CLK_GEN_EDGE_STROBE_EN
    checks++;
    if (rise_stb !== 1'b0 || fall_stb !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobes rise=%b fall=%b expected=0/0", rise_stb, fall_stb);
    end
`endif
    enable = 1'b0; start_value = 1'b0; puls_period = 4'd6;
    repeat (2) tick();
    rst = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      checks++;
      if (clk_out !== 1'b0) begin
        errors++;
        $display("FAIL idle_low cycle=%0d clk_out=%b expected=0", i, clk_out);
      end
    end
  endtask

  task automatic test_idle_level();
    rst = 1'b1;
    enable = 1'b0; start_value = 1'b1; puls_period = 4'd6;
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (clk_out !== 1'b1) begin
      errors++;
      $display("FAIL idle_high_first clk_out=%b expected=1", clk_out);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (clk_out !== 1'b1) begin
        errors++;
        $display("FAIL idle_high_hold cycle=%0d clk_out=%b expected=1", i, clk_out);
      end
    end
  endtask

  task automatic test_basic_period();
    int len;
    enable = 1'b0; start_value = 1'b0; puls_period = 4'd6;
    repeat (2) tick();
    enable = 1'b1;
    tick();
    checks++;
    if (clk_out !== 1'b0) begin
      errors++;
      $display("FAIL basic_start clk_out=%b expected=0", clk_out);
    end
    phase_len(1'b0, len);
    checks++;
    if (len !== 6) begin
      errors++;
      $display("FAIL basic_first_rise cycles=%0d expected=6", len);
    end
    for (int k = 0; k < 2; k++) begin
      phase_len(1'b1, len);
      checks++;
      if (len !== 6) begin
        errors++;
        $display("FAIL basic_high cycles=%0d expected=6", len);
      end
      phase_len(1'b0, len);
      checks++;
      if (len !== 6) begin
        errors++;
        $display("FAIL basic_low cycles=%0d expected=6", len);
      end
    end
  endtask

  task automatic test_period_zero();
    logic prev;
    enable = 1'b0; start_value = 1'b0; puls_period = 4'd0;
    repeat (2) tick();
    enable = 1'b1;
    tick();
    prev = clk_out;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (clk_out === prev || clk_out !== m_level) begin
        errors++;
        $display("FAIL div2 cycle=%0d clk_out=%b prev=%b expected=%b", i, clk_out, prev, m_level);
      end
      prev = clk_out;
    end
  endtask

  task automatic test_period_change();
    int len;
    enable = 1'b0; start_value = 1'b0; puls_period = 4'd6;
    repeat (2) tick();
    enable = 1'b1;
    tick();
    repeat (2) tick();
    puls_period = 4'd2;
    phase_len(1'b0, len);
    checks++;
    if (len + 2 !== 6) begin
      errors++;
      $display("FAIL change_current_phase cycles=%0d expected=6", len + 2);
    end
    phase_len(1'b1, len);
    checks++;
    if (len !== 2) begin
      errors++;
      $display("FAIL change_next_high cycles=%0d expected=2", len);
    end
    phase_len(1'b0, len);
    checks++;
    if (len !== 2) begin
      errors++;
      $display("FAIL change_next_low cycles=%0d expected=2", len);
    end
  endtask

  task automatic test_disable_mid();
    int len;
    enable = 1'b0; start_value = 1'b0; puls_period = 4'd3;
    repeat (2) tick();
    enable = 1'b1;
    tick();
    phase_len(1'b0, len);
    tick();
    enable = 1'b0;
    tick();
    checks++;
    if (clk_out !== 1'b0) begin
      errors++;
      $display("FAIL disable_idle clk_out=%b expected=0", clk_out);
    end
`ifdef CLK_GEN_EDGE_STROBE_EN
    checks++;
    if (fall_stb !== 1'b1 || rise_stb !== 1'b0) begin
      errors++;
      $display("FAIL disable_fall_stb fall=%b rise=%b expected=1/0", fall_stb, rise_stb);
    end
    tick();
    checks++;
    if (fall_stb !== 1'b0) begin
      errors++;
      $display("FAIL disable_fall_single fall=%b expected=0", fall_stb);
    end
`endif
    enable = 1'b1;
    tick();
    phase_len(1'b0, len);
    checks++;
    if (len !== 3) begin
      errors++;
      $display("FAIL reenable_full_phase cycles=%0d expected=3", len);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) enable = ~enable;
      if ($urandom_range(0, 9) == 0) start_value = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 14) == 0) begin
        if ($urandom_range(0, 7) == 0) puls_period = 4'($urandom_range(8, 15));
        else puls_period = 4'($urandom_range(0, 5));
      end
      tick();
      checks++;
      if (clk_out !== m_level) begin
        errors++;
        $display("FAIL random_clk_out cycle=%0d clk_out=%b expected=%b", i, clk_out, m_level);
      end
`ifdef CLK_GEN_EDGE_STROBE_EN
      checks++;
      if (rise_stb !== m_rise || fall_stb !== m_fall) begin
        errors++;
        $display("FAIL random_strobes cycle=%0d rise=%b fall=%b expected=%b/%b",
                 i, rise_stb, fall_stb, m_rise, m_fall);
      end
`endif
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    model_reset();
    rst = 1'b1;
    enable = 1'b0;
    start_value = 1'b0;
    puls_period = 4'd6;
    repeat (2) tick();
    rst = 1'b0;
    test_reset();
    test_idle_level();
    test_basic_period();
    test_period_zero();
    test_period_change();
    test_disable_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
